// File: rtl/seg7_io_display_if.sv
// CPU IO write bus into the seven-segment display peripheral.
// Carries io_we/io_sel/io_wdata; master = CPU side, slave = peripheral.
interface seg7_io_display_if;
    logic        io_we;
    logic        io_sel;
    logic [23:0] io_wdata;

    modport master (
        output io_we,
        output io_sel,
        output io_wdata
    );

    modport slave (
        input io_we,
        input io_sel,
        input io_wdata
    );
endinterface

// File: rtl/seg7_io_display.sv
// Eight-digit multiplexed seven-segment display on the 24-bit IO write bus.
// Ports: clock, reset (async active-low), io (IO write bus, slave),
//        seg_n {dp,g..a} and an_n (active-low), pending, frame_sync.
module seg7_io_display #(
    parameter int SCAN_DIV  = 50000,
    parameter int BLANK_CYC = 64
) (
    input  logic                clock,
    input  logic                reset,
    seg7_io_display_if.slave    io,
    output logic [7:0]          seg_n,
    output logic [7:0]          an_n,
    output logic                pending,
    output logic                frame_sync
);

    localparam int PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] TICK_V  = PW'(SCAN_DIV - 1);
    localparam logic [PW-1:0] BLANK_V = PW'(BLANK_CYC);

    logic [PW-1:0] presc;
    logic [2:0]    idx;
    logic          tick;
    logic          commit;

    logic [23:0]   sh_data;
    logic [23:0]   sh_ctrl;
    logic [23:0]   act_data;
    logic [23:0]   act_ctrl;

    logic [3:0]    nib;
    logic          lz_blank;
    logic          dp_on;
    logic [7:0]    seg_nx;
    logic [7:0]    an_nx;

    // Reserved control bits are kept in the register but drive nothing.
    logic          unused_rsvd;
    assign unused_rsvd = ^act_ctrl[23:18];

    assign tick       = (presc == TICK_V);
    assign commit     = tick && (idx == 3'd7);
    assign frame_sync = commit;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        logic [6:0] s;
        unique case (n)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            4'hF: s = 7'b0001110;
        endcase
        return s;
    endfunction

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            presc <= '0;
            idx   <= 3'd0;
        end else if (tick) begin
            presc <= '0;
            idx   <= idx + 3'd1;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sh_data <= 24'd0;
            sh_ctrl <= 24'd0;
        end else if (io.io_we) begin
            if (io.io_sel) sh_ctrl <= io.io_wdata;
            else           sh_data <= io.io_wdata;
        end
    end

    // Commit samples the shadow as it stood before this edge, so a write
    // landing on the commit edge waits for the next frame.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            act_data <= 24'd0;
            act_ctrl <= 24'd0;
        end else if (commit) begin
            act_data <= sh_data;
            act_ctrl <= sh_ctrl;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)         pending <= 1'b0;
        else if (io.io_we)  pending <= 1'b1;
        else if (commit)    pending <= 1'b0;
    end

    always_comb begin
        nib = 4'h0;
        unique case (idx)
            3'd0: nib = act_data[3:0];
            3'd1: nib = act_data[7:4];
            3'd2: nib = act_data[11:8];
            3'd3: nib = act_data[15:12];
            3'd4: nib = act_data[19:16];
            3'd5: nib = act_data[23:20];
            3'd6: nib = act_ctrl[3:0];
            3'd7: nib = act_ctrl[7:4];
        endcase
    end

    // Digit k (1..5) is blank when it and every higher data digit are zero.
    always_comb begin
        lz_blank = 1'b0;
        if (act_ctrl[9] && idx >= 3'd1 && idx <= 3'd5) begin
            lz_blank = ((act_data >> {idx, 2'b00}) == 24'd0);
        end
    end

    always_comb begin
        dp_on  = act_ctrl[5'd10 + {2'b00, idx}];
        an_nx  = 8'hFF;
        seg_nx = 8'hFF;
        if (act_ctrl[8] && presc >= BLANK_V) begin
            an_nx  = ~(8'b1 << idx);
            seg_nx = {~dp_on, lz_blank ? 7'h7F : hex7(nib)};
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            seg_n <= 8'hFF;
            an_n  <= 8'hFF;
        end else begin
            seg_n <= seg_nx;
            an_n  <= an_nx;
        end
    end

endmodule
